// File: rtl/booth_mult.sv
// ============================================================================
// Module      : booth_mult
// Description : Sequential signed radix-2 Booth multiplier, one step per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mult #(
   parameter  int A_W = 12,
   parameter  int B_W = 8,
   localparam int P_W = A_W + B_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [A_W-1:0]        a,
   input  logic [B_W-1:0]        b,
   output logic                  busy,
   output logic                  done,
   output logic signed [P_W-1:0] p
);

   localparam int                 C_CNT_W = $clog2(B_W + 1);
   localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(B_W - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [A_W:0]       r_a, w_a_nxt;
   logic [B_W-1:0]     r_q, w_q_nxt;
   logic               r_q1, w_q1_nxt;
   logic [A_W:0]       r_m, w_m_nxt;
   logic [C_CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [P_W-1:0]     r_p, w_p_nxt;
   logic               r_done, w_done_nxt;
   logic               r_busy, w_busy_nxt;

   logic [A_W:0]       w_a_step;
   logic [A_W:0]       w_a_sh;
   logic [B_W-1:0]     w_q_sh;
   logic               w_q1_sh;

   // One Booth step on the working register: add/sub M, then arithmetic shift.
   always_comb begin
      w_a_step = r_a;
      case ({r_q[0], r_q1})
         2'b01:   w_a_step = r_a + r_m;
         2'b10:   w_a_step = r_a - r_m;
         default: w_a_step = r_a;
      endcase
      w_a_sh  = {w_a_step[A_W], w_a_step[A_W:1]};
      w_q_sh  = {w_a_step[0], r_q[B_W-1:1]};
      w_q1_sh = r_q[0];
   end

   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_q_nxt     = r_q;
      w_q1_nxt    = r_q1;
      w_m_nxt     = r_m;
      w_cnt_nxt   = r_cnt;
      w_p_nxt     = r_p;
      w_done_nxt  = 1'b0;
      w_busy_nxt  = r_busy;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_a_nxt     = '0;
               w_q_nxt     = b;
               w_q1_nxt    = 1'b0;
               w_m_nxt     = {a[A_W-1], a};
               w_cnt_nxt   = '0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            w_a_nxt   = w_a_sh;
            w_q_nxt   = w_q_sh;
            w_q1_nxt  = w_q1_sh;
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == C_LAST) begin
               // The product fits in P_W bits, so the top accumulator bit is dropped.
               w_p_nxt     = {w_a_sh[A_W-1:0], w_q_sh};
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_q     <= '0;
         r_q1    <= 1'b0;
         r_m     <= '0;
         r_cnt   <= '0;
         r_p     <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_a     <= w_a_nxt;
         r_q     <= w_q_nxt;
         r_q1    <= w_q1_nxt;
         r_m     <= w_m_nxt;
         r_cnt   <= w_cnt_nxt;
         r_p     <= w_p_nxt;
         r_done  <= w_done_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign p    = r_p;

endmodule

`default_nettype wire

// File: tb/tb_booth_mult.sv
// ============================================================================
// Module      : tb_booth_mult
// Description : Directed self-checking bench for booth_mult.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_mult;

   localparam int A_W = 12;
   localparam int B_W = 8;
   localparam int P_W = A_W + B_W;

   logic                  clk;
   logic                  rst;
   logic                  start;
   logic [A_W-1:0]        a;
   logic [B_W-1:0]        b;
   logic                  busy;
   logic                  done;
   logic signed [P_W-1:0] p;

   int checks   = 0;
   int failures = 0;
   int lat;
   int nbusy;
   int overlap;
   int bad;
   int acc_sum;

   booth_mult #(.A_W(A_W), .B_W(B_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .p     (p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called #1 after the accepting edge; returns edges until done (bounded).
   task automatic wait_done(output int n_lat, output int n_busy);
      n_lat  = 0;
      n_busy = busy ? 1 : 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         n_lat++;
         if (busy && done) overlap++;
         if (done) break;
         if (busy) n_busy++;
      end
   endtask

   task automatic do_mult(input int ai, input int bi, input longint exp, input string tag);
      a     = A_W'(ai);
      b     = B_W'(bi);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a     = A_W'($urandom);
      b     = B_W'($urandom);
      wait_done(lat, nbusy);
      chk({tag, "_latency"}, lat, 8);
      chk({tag, "_p"}, longint'(p), exp);
      @(posedge clk); #1;
      chk({tag, "_done_1cyc"}, longint'(done), 0);
   endtask

   initial begin
      overlap = 0;
      rst   = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #12;
      chk("rst_busy", longint'(busy), 0);
      chk("rst_done", longint'(done), 0);
      chk("rst_p", longint'(p), 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      // Basic multiply with busy-length check
      a = 12'd3; b = 8'd11; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("basic_busy_after_E0", longint'(busy), 1);
      wait_done(lat, nbusy);
      chk("basic_latency", lat, 8);
      chk("basic_busy_cycles", nbusy, 8);
      chk("basic_p", longint'(p), 33);
      @(posedge clk); #1;
      chk("basic_done_1cyc", longint'(done), 0);
      chk("basic_p_hold", longint'(p), 33);

      do_mult(-3, 11, -33, "neg3x11");
      chk("neg3x11_hex", longint'(unsigned'(p)), 64'h0FFFDF);
      do_mult(-10, 11, -110, "neg10x11");
      do_mult(5, -1, -5, "5xneg1");

      do_mult(-2048, -128, 262144, "minxmin");
      do_mult(2047, 127, 259969, "maxxmax");
      do_mult(-2048, 127, -260096, "minxmax");
      do_mult(0, -128, 0, "zeroxmin");
      do_mult(2047, -128, -262016, "maxxmin");

      // Back-to-back with start held high and operands changing during RUN
      a = 12'd7; b = -8'sd3; start = 1'b1;
      @(posedge clk); #1;
      a = -12'sd9; b = 8'd13;
      wait_done(lat, nbusy);
      chk("b2b1_latency", lat, 8);
      chk("b2b1_p", longint'(p), -21);
      @(posedge clk); #1;
      chk("b2b2_accepted", longint'(busy), 1);
      a = 12'd55; b = -8'sd7;
      wait_done(lat, nbusy);
      chk("b2b2_period", lat + 1, 9);
      chk("b2b2_p", longint'(p), -117);
      @(posedge clk); #1;
      start = 1'b0;
      a = 12'd1000; b = 8'd99;
      wait_done(lat, nbusy);
      chk("b2b3_period", lat + 1, 9);
      chk("b2b3_p", longint'(p), -385);
      chk("busy_done_overlap", overlap, 0);

      // Asynchronous reset mid-operation
      a = 12'd100; b = 8'd50; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_busy", longint'(busy), 0);
      chk("midrst_done", longint'(done), 0);
      chk("midrst_p", longint'(p), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done || busy || (p != '0)) bad++;
      end
      chk("midrst_no_done", bad, 0);
      do_mult(2, 11, 22, "post_rst");

      // Chain into a done-gated accumulator
      begin
         int samples [8] = '{1, 2, 3, 4, -3, 2, -5, -10};
         int sums    [8] = '{11, 33, 66, 110, 77, 99, 44, -66};
         acc_sum = 0;
         for (int k = 0; k < 8; k++) begin
            a = A_W'(samples[k]); b = 8'd11; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            wait_done(lat, nbusy);
            if (done) acc_sum += int'(p);
            @(posedge clk); #1;
            if (done) acc_sum += int'(p);
            chk($sformatf("acc_%0d", k), acc_sum, sums[k]);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/booth_mult.md
# booth_mult

Sequential signed radix-2 Booth multiplier that produces the 20-bit product samples consumed by the `acc` accumulator stage. Each product is a 12-bit signed data sample times an 8-bit signed coefficient. It takes one operand pair per start pulse and iterates one Booth step per clock. It presents the exact 20-bit two's-complement product with a one-cycle `done` strobe. `p` connects directly to `acc.din`.

## Interface
- `A_W`, 12, multiplicand (data sample) width, signed
- `B_W`, 8, multiplier (coefficient) width, signed; also the iteration count
- `P_W`, `A_W+B_W` (20), product width; fixed derived value, not overridden independently
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset; asserting it (0) clears all state immediately, independent of `clk`
- `start`  in  1  request; sampled on the rising edge, accepted only while IDLE
- `a`  in  `A_W`  signed multiplicand; captured at the accepting edge
- `b`  in  `B_W`  signed multiplier; captured at the accepting edge
- `busy`  out  1  high while an operation is in progress (RUN state)
- `done`  out  1  one-cycle pulse; `p` is updated in the same cycle
- `p`  out  `P_W`  signed product; holds its value until the next `done`

## Operation
- States:
  - IDLE, RUN.
  - Reset state IDLE.
  - Reset values: `busy`=0, `done`=0, `p`=0, iteration counter=0, working registers=0.
- IDLE:
  - If `start`=1 at an edge, load the working register `{A_reg = 0 (A_W+1 bits), Q = b, q_1 = 0}`, latch `a` sign-extended to A_W+1 bits as `M`, clear the counter, and go to RUN.
  - If `start`=0, stay in IDLE.
- RUN: each edge performs one Booth step:
  - Pair `{Q[0], q_1}`: 01 gives A_reg += M; 10 gives A_reg -= M; 00 and 11 make no change.
  - Then arithmetic-shift-right the whole `{A_reg, Q, q_1}` by 1, preserving the sign.
  - Increment the counter.
- On the edge that completes step `B_W`:
  - `p` <= `{A_reg[A_W-1:0], Q}` (low P_W bits of the product).
  - `done` <= 1 and `busy` <= 0.
  - State goes to IDLE.
- `start` asserted while in RUN is ignored. It is not queued, and the operands are not re-captured.
- `a` and `b` may change freely after the accepting edge.
- Arithmetic:
  - Exact two's-complement result for all operand pairs.
  - Extremes: -2048 × -128 = 262144 and 2047 × -128 = -262016, both within the 20-bit range.
  - An internal A_W+1-bit accumulator avoids overflow when subtracting M = -2048.
- Reset mid-operation:
  - The in-flight product is discarded and `p` returns to 0.
  - No `done` pulse is produced for the discarded product.
  - After reset releases, the block waits in IDLE for a new `start`.

## Timing
- Latency:
  - The start is accepted at edge E0.
  - `busy`=1 from after E0 through after E(B_W-1).
  - After E(B_W) (E8 for the default widths), `done`=1 for exactly one cycle and `p` is valid.
- `p` stays stable from E(B_W) until the next operation's completing edge.
- The earliest back-to-back start is sampled at E(B_W+1), since `start` may be held high during the `done` cycle. That gives one product per B_W+1 = 9 clocks.
- `done` and `busy` are never high in the same cycle.
- No combinational path from inputs to outputs; all outputs are registered.
- The downstream `acc` samples `p` every clock. Because `p` holds between updates, `acc` re-accumulates the held value unless the top level gates `acc` with `done`. Gating is a top-level responsibility, not this block's.

## Test plan
- Basic multiply:
  - Stimulus: after reset, `a`=3, `b`=11, pulse `start`.
  - Required: `done` 8 cycles after the accepting edge, `p`=33, `busy` high for 8 cycles.
- Signed operands:
  - Stimulus: (a,b) = (-3,11), (-10,11), (5,-1), in turn.
  - Required: `p` = -33 (0xFFFDF), -110, -5, respectively.
- Extremes:
  - Stimulus: (-2048,-128), (2047,127), (-2048,127), (0,-128), in turn.
  - Required: `p` = 262144, 259969, -260096, 0, respectively.
- Back-to-back and ignored start:
  - Stimulus: hold `start`=1 continuously with changing operands.
  - Required: exactly one `done` per 9 clocks; results match the operands captured at each accepting edge; operand changes during RUN have no effect.
- Reset mid-operation:
  - Stimulus: assert `rst`=0 asynchronously 4 cycles into RUN.
  - Required: `busy`, `done`, `p` go to 0 immediately, with no `done` pulse. After release, `a`=2, `b`=11 gives `p`=22.
- Chain with `acc`:
  - Stimulus: feed `p` into `acc` with `done` gating, for the sample sequence 1, 2, 3, 4, -3, 2, -5, -10 × b=11.
  - Required: `acc` output equals the running sum: 11, 33, 66, 110, 77, 99, 44, -66.
